// File: rtl/accel_pkg.sv
// accel_pkg: shared types and constants for the host streamer.
// State encoding, config word count and neuron-count word indices.
package accel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    GAP,
    VALID,
    STREAM,
    WAIT_DONE
  } state_t;

  localparam int CFG_WORDS   = 5;
  localparam int IN_CNT_IDX  = 3;
  localparam int OUT_CNT_IDX = 4;

endpackage

// File: rtl/wt_prefetch_fifo.sv
// wt_prefetch_fifo: weight prefetch buffer, PF_DEPTH entries of DW bits.
// Ports: push/wdata in, pop/rdata out (show-ahead), full, empty, count.
module wt_prefetch_fifo #(
  parameter int PF_DEPTH = 4,
  parameter int DW = 16,
  localparam int AW = $clog2(PF_DEPTH),
  localparam int CW = $clog2(PF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [PF_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == CW'(PF_DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/accel_host_streamer.sv
// accel_host_streamer: writes 5 config words to the accelerator, then
// streams word3*word4 prefetched weights on demand; mem_* is the store.
module accel_host_streamer
  import accel_pkg::*;
#(
  parameter int DW = 16,
  parameter int PF_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [CFG_WORDS-1:0][DW-1:0]  cfg_words,
  input  logic [DW-1:0]                 weight_base,
  output logic                          CPUEnable,
  output logic                          busrdwr,
  output logic [DW-1:0]                 data_bus,
  output logic                          DVAL,
  input  logic                          SRAM_RdReq,
  output logic [DW-1:0]                 DRAMdata,
  input  logic                          cpu_neuron_done,
  output logic                          mem_rd,
  output logic [DW-1:0]                 mem_addr,
  input  logic [DW-1:0]                 mem_rdata,
  input  logic                          mem_rvalid,
  output logic                          busy,
  output logic                          done,
  output logic                          err_underrun,
  output logic                          err_overrun
);

  localparam int CW = $clog2(PF_DEPTH + 1);
  localparam int NW = 2 * DW;

  state_t                       state;
  logic [CFG_WORDS-1:0][DW-1:0] cfg_r;
  logic [DW-1:0]                base_r;
  logic [NW-1:0]                total;
  logic [NW-1:0]                issued;
  logic [NW-1:0]                served;
  logic [2:0]                   k;
  logic [2:0]                   k_nxt;
  logic [CW-1:0]                outst;
  logic [CW-1:0]                fcount;
  logic [CW:0]                  inflight;
  logic                         discard;
  logic                         fetching;
  logic                         ffull;
  logic                         fempty;
  logic                         push;
  logic                         pop;
  logic [DW-1:0]                frdata;

  assign busy     = state != IDLE;
  assign fetching = state inside {CFG, GAP, VALID, STREAM};
  assign inflight = {1'b0, fcount} + {1'b0, outst};
  assign mem_rd   = fetching && (issued < total)
                 && (inflight < {1'b0, CW'(PF_DEPTH)});
  assign mem_addr = base_r + issued[DW-1:0];
  assign k_nxt    = k + 3'd1;

  // Returns still in flight from before a reset are dropped until
  // the next job issues its first read.
  assign push = mem_rvalid && !discard && (outst != '0) && !ffull;
  // No bypass: a pop only sees words already in the buffer.
  assign pop  = SRAM_RdReq && (state == STREAM) && !fempty;

  wt_prefetch_fifo #(
    .PF_DEPTH(PF_DEPTH),
    .DW(DW)
  ) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .wdata(mem_rdata),
    .pop(pop),
    .rdata(frdata),
    .full(ffull),
    .empty(fempty),
    .count(fcount)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cfg_r        <= '0;
      base_r       <= '0;
      total        <= '0;
      issued       <= '0;
      served       <= '0;
      k            <= '0;
      outst        <= '0;
      discard      <= 1'b1;
      CPUEnable    <= 1'b0;
      busrdwr      <= 1'b0;
      data_bus     <= '0;
      DVAL         <= 1'b0;
      DRAMdata     <= '0;
      done         <= 1'b0;
      err_underrun <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (mem_rd) begin
        issued  <= issued + NW'(1);
        discard <= 1'b0;
      end
      if (mem_rd && !push) outst <= outst + CW'(1);
      else if (!mem_rd && push) outst <= outst - CW'(1);
      if (pop) begin
        DRAMdata <= frdata;
        served   <= served + NW'(1);
      end
      if (SRAM_RdReq) begin
        if (state != STREAM) err_overrun <= 1'b1;
        else if (fempty) err_underrun <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            cfg_r        <= cfg_words;
            base_r       <= weight_base;
            total        <= NW'(cfg_words[IN_CNT_IDX])
                          * NW'(cfg_words[OUT_CNT_IDX]);
            issued       <= '0;
            served       <= '0;
            k            <= '0;
            err_underrun <= 1'b0;
            err_overrun  <= 1'b0;
            CPUEnable    <= 1'b1;
            busrdwr      <= 1'b1;
            data_bus     <= cfg_words[0];
            state        <= CFG;
          end
        end
        CFG: begin
          if (k == 3'(CFG_WORDS - 1)) begin
            busrdwr <= 1'b0;
            state   <= GAP;
          end else begin
            k        <= k_nxt;
            data_bus <= cfg_r[k_nxt];
          end
        end
        GAP: begin
          DVAL  <= 1'b1;
          state <= VALID;
        end
        VALID: begin
          DVAL  <= 1'b0;
          state <= (total == '0) ? WAIT_DONE : STREAM;
        end
        STREAM: begin
          if (pop && (served + NW'(1) == total)) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (cpu_neuron_done) begin
            CPUEnable <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_host_streamer.sv
// tb_accel_host_streamer: directed scenario tasks for the host streamer.
// Memory responder returns 0x0800+addr after a programmable latency.
module tb_accel_host_streamer;

  logic              clk;
  logic              reset;
  logic              start;
  logic [4:0][15:0]  cfg_words;
  logic [15:0]       weight_base;
  logic              CPUEnable;
  logic              busrdwr;
  logic [15:0]       data_bus;
  logic              DVAL;
  logic              SRAM_RdReq;
  logic [15:0]       DRAMdata;
  logic              cpu_neuron_done;
  logic              mem_rd;
  logic [15:0]       mem_addr;
  logic [15:0]       mem_rdata;
  logic              mem_rvalid;
  logic              busy;
  logic              done;
  logic              err_underrun;
  logic              err_overrun;

  int checks;
  int errors;
  int lat;
  int cyc;
  logic [15:0] pq_a[$];
  int          pq_d[$];

  accel_host_streamer #(.DW(16), .PF_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .cfg_words(cfg_words),
    .weight_base(weight_base),
    .CPUEnable(CPUEnable),
    .busrdwr(busrdwr),
    .data_bus(data_bus),
    .DVAL(DVAL),
    .SRAM_RdReq(SRAM_RdReq),
    .DRAMdata(DRAMdata),
    .cpu_neuron_done(cpu_neuron_done),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid),
    .busy(busy),
    .done(done),
    .err_underrun(err_underrun),
    .err_overrun(err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      pq_a.delete();
      pq_d.delete();
    end else if (mem_rd) begin
      pq_a.push_back(mem_addr);
      pq_d.push_back(cyc + lat);
    end
    #1;
    if (pq_a.size() != 0 && pq_d[0] <= cyc + 1) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 16'h0800 + pq_a.pop_front();
      void'(pq_d.pop_front());
    end else begin
      mem_rvalid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [15:0] w3, input logic [15:0] w4,
                          input logic [15:0] base);
    cfg_words[0] = 16'h0000;
    cfg_words[1] = 16'h0010;
    cfg_words[2] = 16'h0011;
    cfg_words[3] = w3;
    cfg_words[4] = w4;
    weight_base  = base;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({CPUEnable, busrdwr, data_bus, DVAL, DRAMdata, mem_rd, mem_addr,
         busy, done, err_underrun, err_overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b wr=%b bus=%h dval=%b dd=%h rd=%b a=%h busy=%b done=%b u=%b o=%b expected all 0",
               CPUEnable, busrdwr, data_bus, DVAL, DRAMdata, mem_rd,
               mem_addr, busy, done, err_underrun, err_overrun);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b mem_rd=%b expected 0 0",
               busy, mem_rd);
    end
  endtask

  task automatic test_cfg();
    logic [15:0] w [5];
    w = '{16'h0000, 16'h0010, 16'h0011, 16'h0010, 16'h0001};
    lat = 1;
    load_cfg(16'h0010, 16'h0001, 16'h0000);
    pulse_start();
    for (int i = 0; i < 5; i++) cfg_words[i] = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (busrdwr !== 1'b1 || data_bus !== w[i] || CPUEnable !== 1'b1
          || busy !== 1'b1 || DVAL !== 1'b0) begin
        errors++;
        $display("FAIL cfg_word%0d: wr=%b bus=%h en=%b busy=%b dval=%b expected 1 %h 1 1 0",
                 i, busrdwr, data_bus, CPUEnable, busy, DVAL, w[i]);
      end
      if (i < 4) tick();
    end
    tick();
    checks++;
    if (busrdwr !== 1'b0 || data_bus !== 16'h0001 || DVAL !== 1'b0) begin
      errors++;
      $display("FAIL cfg_gap: wr=%b bus=%h dval=%b expected 0 0001 0",
               busrdwr, data_bus, DVAL);
    end
    tick();
    checks++;
    if (DVAL !== 1'b1 || busrdwr !== 1'b0) begin
      errors++;
      $display("FAIL cfg_dval: dval=%b wr=%b expected 1 0", DVAL, busrdwr);
    end
    tick();
    checks++;
    if (DVAL !== 1'b0 || CPUEnable !== 1'b1) begin
      errors++;
      $display("FAIL cfg_dval_end: dval=%b en=%b expected 0 1",
               DVAL, CPUEnable);
    end
  endtask

  task automatic test_stream();
    SRAM_RdReq = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (DRAMdata !== 16'h0800 + 16'(i)) begin
        errors++;
        $display("FAIL stream_word%0d: got %h expected %h",
                 i, DRAMdata, 16'h0800 + 16'(i));
      end
    end
    checks++;
    if (err_underrun !== 1'b0 || err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL stream_flags: u=%b o=%b expected 0 0",
               err_underrun, err_overrun);
    end
    tick();
    SRAM_RdReq = 1'b0;
    checks++;
    if (err_overrun !== 1'b1 || DRAMdata !== 16'h080F
        || err_underrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun: o=%b dd=%h u=%b expected 1 080f 0",
               err_overrun, DRAMdata, err_underrun);
    end
    cpu_neuron_done = 1'b1;
    tick();
    cpu_neuron_done = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || CPUEnable !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b en=%b expected 1 0 0",
               done, busy, CPUEnable);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done=%b expected 0", done);
    end
  endtask

  task automatic test_underrun();
    logic [15:0] prev;
    int got;
    got = 0;
    lat = 6;
    load_cfg(16'h0010, 16'h0001, 16'h0000);
    pulse_start();
    checks++;
    if (err_overrun !== 1'b0 || err_underrun !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_on_start: o=%b u=%b expected 0 0",
               err_overrun, err_underrun);
    end
    for (int i = 0; i < 7; i++) tick();
    SRAM_RdReq = 1'b1;
    for (int c = 0; c < 300 && got < 16; c++) begin
      prev = DRAMdata;
      tick();
      if (DRAMdata !== prev) begin
        checks++;
        if (DRAMdata !== 16'h0800 + 16'(got)) begin
          errors++;
          $display("FAIL underrun_word%0d: got %h expected %h",
                   got, DRAMdata, 16'h0800 + 16'(got));
        end
        got++;
        if (got == 16) SRAM_RdReq = 1'b0;
      end
    end
    SRAM_RdReq = 1'b0;
    checks++;
    if (got !== 16) begin
      errors++;
      $display("FAIL underrun_count: got %0d words expected 16", got);
    end
    checks++;
    if (err_underrun !== 1'b1 || err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_flags: u=%b o=%b expected 1 0",
               err_underrun, err_overrun);
    end
    cpu_neuron_done = 1'b1;
    tick();
    cpu_neuron_done = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL underrun_done: done=%b busy=%b expected 1 0",
               done, busy);
    end
    tick();
  endtask

  task automatic test_zero();
    logic seen_rd;
    lat = 1;
    load_cfg(16'h0005, 16'h0000, 16'h0040);
    pulse_start();
    seen_rd = mem_rd;
    cpu_neuron_done = 1'b1;
    tick();
    cpu_neuron_done = 1'b0;
    seen_rd = seen_rd | mem_rd;
    checks++;
    if (busy !== 1'b1 || busrdwr !== 1'b1 || data_bus !== 16'h0010) begin
      errors++;
      $display("FAIL zero_done_ignored: busy=%b wr=%b bus=%h expected 1 1 0010",
               busy, busrdwr, data_bus);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      seen_rd = seen_rd | mem_rd;
    end
    checks++;
    if (busy !== 1'b1 || DVAL !== 1'b0 || CPUEnable !== 1'b1) begin
      errors++;
      $display("FAIL zero_wait: busy=%b dval=%b en=%b expected 1 0 1",
               busy, DVAL, CPUEnable);
    end
    SRAM_RdReq = 1'b1;
    tick();
    SRAM_RdReq = 1'b0;
    seen_rd = seen_rd | mem_rd;
    checks++;
    if (err_overrun !== 1'b1 || err_underrun !== 1'b0) begin
      errors++;
      $display("FAIL zero_skip_stream: o=%b u=%b expected 1 0",
               err_overrun, err_underrun);
    end
    checks++;
    if (seen_rd !== 1'b0) begin
      errors++;
      $display("FAIL zero_no_mem_rd: seen=%b expected 0", seen_rd);
    end
    cpu_neuron_done = 1'b1;
    tick();
    cpu_neuron_done = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || CPUEnable !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b en=%b expected 1 0 0",
               done, busy, CPUEnable);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    lat = 1;
    load_cfg(16'h0010, 16'h0001, 16'h0020);
    pulse_start();
    for (int i = 0; i < 7; i++) tick();
    SRAM_RdReq = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (DRAMdata !== 16'h0826) begin
      errors++;
      $display("FAIL mid_seventh: got %h expected 0826", DRAMdata);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (CPUEnable !== 1'b0 || DRAMdata !== 16'h0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: en=%b dd=%h busy=%b expected 0 0000 0",
               CPUEnable, DRAMdata, busy);
    end
    SRAM_RdReq = 1'b0;
    tick();
    checks++;
    if ({CPUEnable, busrdwr, data_bus, DVAL, DRAMdata, mem_rd, mem_addr,
         busy, done, err_underrun, err_overrun} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: en=%b wr=%b bus=%h dd=%h rd=%b a=%h busy=%b expected all 0",
               CPUEnable, busrdwr, data_bus, DRAMdata, mem_rd, mem_addr,
               busy);
    end
    reset = 1'b0;
    tick();
    tick();
    pulse_start();
    for (int i = 0; i < 7; i++) tick();
    SRAM_RdReq = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (DRAMdata !== 16'h0820 + 16'(i)) begin
        errors++;
        $display("FAIL rerun_word%0d: got %h expected %h",
                 i, DRAMdata, 16'h0820 + 16'(i));
      end
    end
    SRAM_RdReq = 1'b0;
    checks++;
    if (err_underrun !== 1'b0 || err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL rerun_flags: u=%b o=%b expected 0 0",
               err_underrun, err_overrun);
    end
    cpu_neuron_done = 1'b1;
    tick();
    cpu_neuron_done = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rerun_done: done=%b busy=%b expected 1 0", done, busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks          = 0;
    errors          = 0;
    lat             = 1;
    cyc             = 0;
    reset           = 1'b1;
    start           = 1'b0;
    SRAM_RdReq      = 1'b0;
    cpu_neuron_done = 1'b0;
    cfg_words       = '0;
    weight_base     = '0;
    mem_rvalid      = 1'b0;
    mem_rdata       = '0;
    test_reset();
    test_cfg();
    test_stream();
    test_underrun();
    test_zero();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
